// File: rtl/sram_resp_agent_pkg.sv
// Shared definitions for the sram-like bus responder: size encodings,
// default widths and the layout of one outstanding-request queue entry.
package sram_resp_agent_pkg;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_MEM_AW     = 8;
    localparam int DEF_LAT_WIDTH  = 4;

    // Entry layout at the default widths; the queue builds the same shape
    // from its own parameters so non-default configurations stay consistent.
    typedef struct packed {
        logic                        valid;
        logic                        wr;
        logic [DEF_MEM_AW-1:0]       idx;
        logic [DEF_DATA_WIDTH-1:0]   wdata;
        logic [DEF_DATA_WIDTH/8-1:0] wstrb;
        logic [DEF_LAT_WIDTH-1:0]    ctr;
    } q_entry_t;

endpackage

// File: rtl/sram_resp_agent_resp_lat_queue.sv
// In-order circular request queue with per-entry latency counters; the
// oldest entry is presented for response once its counter reaches zero.
module resp_lat_queue
    import sram_resp_agent_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int MEM_AW      = DEF_MEM_AW,
    parameter int QUEUE_DEPTH = 4,
    parameter int QPTR_WIDTH  = 2,
    parameter int RESP_LAT    = 2,
    parameter int LAT_WIDTH   = DEF_LAT_WIDTH
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req,
    input  logic                    wr,
    input  logic [MEM_AW-1:0]       idx,
    input  logic [DATA_WIDTH-1:0]   wdata,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    output logic                    addr_ok,
    output logic                    pop_valid,
    output logic                    pop_wr,
    output logic [MEM_AW-1:0]       pop_idx,
    output logic [DATA_WIDTH-1:0]   pop_wdata,
    output logic [DATA_WIDTH/8-1:0] pop_wstrb
);

    typedef struct packed {
        logic                    valid;
        logic                    wr;
        logic [MEM_AW-1:0]       idx;
        logic [DATA_WIDTH-1:0]   wdata;
        logic [DATA_WIDTH/8-1:0] wstrb;
        logic [LAT_WIDTH-1:0]    ctr;
    } entry_t;

    localparam logic [QPTR_WIDTH:0]    DEPTH_C    = (QPTR_WIDTH+1)'(QUEUE_DEPTH);
    localparam logic [QPTR_WIDTH:0]    CNT_ONE_C  = (QPTR_WIDTH+1)'(1);
    localparam logic [QPTR_WIDTH-1:0]  LAST_C     = QPTR_WIDTH'(QUEUE_DEPTH - 1);
    localparam logic [QPTR_WIDTH-1:0]  PTR_ONE_C  = QPTR_WIDTH'(1);
    localparam logic [LAT_WIDTH-1:0]   LAT_ONE_C  = LAT_WIDTH'(1);
    localparam logic [LAT_WIDTH-1:0]   LAT_INIT_C = LAT_WIDTH'(RESP_LAT - 1);

    entry_t                slot_r [QUEUE_DEPTH];
    logic [QPTR_WIDTH-1:0] head_r;
    logic [QPTR_WIDTH-1:0] tail_r;
    logic [QPTR_WIDTH:0]   count_r;
    logic [QPTR_WIDTH-1:0] head_nxt_s;
    logic [QPTR_WIDTH-1:0] tail_nxt_s;
    logic                  push_s;
    logic                  pop_s;
    entry_t                tail_ent_s;

    // Full check uses the pre-pop count, so a full queue cannot refill in its pop cycle.
    assign addr_ok    = req && (count_r < DEPTH_C);
    assign push_s     = addr_ok;
    assign tail_ent_s = slot_r[tail_r];
    assign pop_s      = tail_ent_s.valid && (tail_ent_s.ctr == {LAT_WIDTH{1'b0}});
    assign head_nxt_s = (head_r == LAST_C) ? {QPTR_WIDTH{1'b0}} : head_r + PTR_ONE_C;
    assign tail_nxt_s = (tail_r == LAST_C) ? {QPTR_WIDTH{1'b0}} : tail_r + PTR_ONE_C;

    assign pop_valid = pop_s;
    assign pop_wr    = tail_ent_s.wr;
    assign pop_idx   = tail_ent_s.idx;
    assign pop_wdata = tail_ent_s.wdata;
    assign pop_wstrb = tail_ent_s.wstrb;

    // Queue state: enqueue at head, retire at tail, age every live entry.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            head_r  <= {QPTR_WIDTH{1'b0}};
            tail_r  <= {QPTR_WIDTH{1'b0}};
            count_r <= {(QPTR_WIDTH+1){1'b0}};
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                slot_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < QUEUE_DEPTH; i++) begin
                if (slot_r[i].valid && (slot_r[i].ctr != {LAT_WIDTH{1'b0}})) begin
                    slot_r[i].ctr <= slot_r[i].ctr - LAT_ONE_C;
                end
            end
            if (pop_s) begin
                slot_r[tail_r].valid <= 1'b0;
                tail_r               <= tail_nxt_s;
            end
            if (push_s) begin
                slot_r[head_r] <= '{valid: 1'b1, wr: wr, idx: idx, wdata: wdata,
                                   wstrb: wstrb, ctr: LAT_INIT_C};
                head_r         <= head_nxt_s;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE_C;
                2'b01:   count_r <= count_r - CNT_ONE_C;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/sram_resp_agent.sv
// Memory-side responder for the sram-like bus: queues requests in order and
// answers each after a fixed minimum latency from a word-addressed RAM.
module sram_resp_agent
    import sram_resp_agent_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int MEM_AW      = DEF_MEM_AW,
    parameter int QUEUE_DEPTH = 4,
    parameter int QPTR_WIDTH  = 2,
    parameter int RESP_LAT    = 2,
    parameter int LAT_WIDTH   = DEF_LAT_WIDTH
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    req,
    input  logic                    wr,
    input  logic [1:0]              size,
    input  logic [DATA_WIDTH/8-1:0] wstrb,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    addr_ok,
    output logic                    data_ok,
    output logic [DATA_WIDTH-1:0]   rdata
);

    logic [DATA_WIDTH-1:0]   mem_r [2**MEM_AW];
    logic [MEM_AW-1:0]       idx_s;
    logic                    pop_valid_s;
    logic                    pop_wr_s;
    logic [MEM_AW-1:0]       pop_idx_s;
    logic [DATA_WIDTH-1:0]   pop_wdata_s;
    logic [DATA_WIDTH/8-1:0] pop_wstrb_s;
    logic                    unused_s;

    // Size is informational and the byte offset / high address bits alias.
    assign idx_s    = addr[MEM_AW+1:2];
    assign unused_s = ^{size, addr[ADDR_WIDTH-1:MEM_AW+2], addr[1:0]};

    resp_lat_queue #(
        .DATA_WIDTH  (DATA_WIDTH),
        .MEM_AW      (MEM_AW),
        .QUEUE_DEPTH (QUEUE_DEPTH),
        .QPTR_WIDTH  (QPTR_WIDTH),
        .RESP_LAT    (RESP_LAT),
        .LAT_WIDTH   (LAT_WIDTH)
    ) u_queue (
        .clk       (clk),
        .resetn    (resetn),
        .req       (req),
        .wr        (wr),
        .idx       (idx_s),
        .wdata     (wdata),
        .wstrb     (wstrb),
        .addr_ok   (addr_ok),
        .pop_valid (pop_valid_s),
        .pop_wr    (pop_wr_s),
        .pop_idx   (pop_idx_s),
        .pop_wdata (pop_wdata_s),
        .pop_wstrb (pop_wstrb_s)
    );

    assign data_ok = pop_valid_s;

    // Writes commit byte-wise when they retire; a reset edge drops them instead.
    always_ff @(posedge clk) begin
        if (resetn && pop_valid_s && pop_wr_s) begin
            for (int b = 0; b < DATA_WIDTH/8; b++) begin
                if (pop_wstrb_s[b]) begin
                    mem_r[pop_idx_s][b*8 +: 8] <= pop_wdata_s[b*8 +: 8];
                end
            end
        end
    end

    // Read data only while a read is retiring; zero otherwise.
    always_comb begin
        rdata = {DATA_WIDTH{1'b0}};
        if (pop_valid_s && !pop_wr_s) begin
            rdata = mem_r[pop_idx_s];
        end else begin
            rdata = {DATA_WIDTH{1'b0}};
        end
    end

endmodule
